// File: rtl/bayes_infer_master.sv
// AXI-Lite initiator for one Bayesian inference job: writes mode and four observations to the
// chip controller, reads back the packed posterior word and returns it on a result stream.
module bayes_infer_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          OBS_W     = 9,
  parameter int          TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [4*OBS_W-1:0] job_obs,
  input  logic               job_mode,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               res_err,
  output logic [31:0]        aw_addr,
  output logic               aw_valid,
  input  logic               aw_ready,
  output logic [2:0]         aw_prot,
  output logic [31:0]        w_data,
  output logic [3:0]         w_strb,
  output logic               w_valid,
  input  logic               w_ready,
  input  logic [1:0]         b_resp,
  input  logic               b_valid,
  output logic               b_ready,
  output logic [31:0]        ar_addr,
  output logic               ar_valid,
  input  logic               ar_ready,
  output logic [2:0]         ar_prot,
  input  logic [31:0]        r_data,
  input  logic [1:0]         r_resp,
  input  logic               r_valid,
  output logic               r_ready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, OUT} state_t;

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [2:0]         wr_idx;
  logic [4*OBS_W-1:0] obs_q;
  logic               mode_q;
  logic               aw_seen, w_seen;
  logic               abort, rd_take, wr_ok;
  logic               cnt_lim, aw_hs, w_hs;
  logic [OBS_W-1:0]   obs_sel;
  logic [15:0]        wr_off;

  assign cnt_lim = (wait_cnt == CNT_LIM);
  // A ready seen earlier in this write is remembered so both channels complete together.
  assign aw_hs   = aw_seen | aw_ready;
  assign w_hs    = w_seen | w_ready;

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    rd_take   = 1'b0;
    wr_ok     = 1'b0;
    case (state)
      IDLE:    if (job_valid && job_ready) state_nxt = WR_REQ;
      WR_REQ: begin
        if (aw_hs && w_hs) state_nxt = WR_RESP;
        else if (cnt_lim)  abort = 1'b1;
      end
      WR_RESP: begin
        if (b_valid) begin
          if (b_resp == 2'b00) begin
            wr_ok     = 1'b1;
            state_nxt = (wr_idx == 3'd4) ? RD_REQ : WR_REQ;
          end else begin
            abort = 1'b1;
          end
        end else if (cnt_lim) begin
          abort = 1'b1;
        end
      end
      RD_REQ: begin
        if (ar_ready)     state_nxt = RD_RESP;
        else if (cnt_lim) abort = 1'b1;
      end
      RD_RESP: begin
        if (r_valid) begin
          rd_take   = 1'b1;
          state_nxt = OUT;
        end else if (cnt_lim) begin
          abort = 1'b1;
        end
      end
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = OUT;
  end

  always_comb begin
    obs_sel = '0;
    wr_off  = 16'h201C;
    case (wr_idx)
      3'd1: begin obs_sel = obs_q[OBS_W-1:0];           wr_off = 16'h200C; end
      3'd2: begin obs_sel = obs_q[2*OBS_W-1:OBS_W];     wr_off = 16'h2010; end
      3'd3: begin obs_sel = obs_q[3*OBS_W-1:2*OBS_W];   wr_off = 16'h2014; end
      3'd4: begin obs_sel = obs_q[4*OBS_W-1:3*OBS_W];   wr_off = 16'h2018; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wr_idx    <= '0;
      obs_q     <= '0;
      mode_q    <= 1'b0;
      aw_seen   <= 1'b0;
      w_seen    <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      job_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      job_ready <= (state_nxt == IDLE);
      if (state_nxt != state) wait_cnt <= '0;
      else if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) wait_cnt <= wait_cnt + CNT_ONE;
      if (state == WR_REQ && state_nxt == WR_REQ) begin
        aw_seen <= aw_hs;
        w_seen  <= w_hs;
      end else begin
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end
      if (state == IDLE && state_nxt == WR_REQ) begin
        obs_q  <= job_obs;
        mode_q <= job_mode;
        wr_idx <= '0;
      end else if (wr_ok) begin
        wr_idx <= wr_idx + 3'd1;
      end
      // A bad read response is reported like any other abort: zero data, error flag set.
      if (abort) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end else if (rd_take) begin
        res_data <= (r_resp == 2'b00) ? r_data : 32'h0;
        res_err  <= (r_resp != 2'b00);
      end
    end
  end

  assign aw_valid  = (state == WR_REQ);
  assign w_valid   = (state == WR_REQ);
  assign b_ready   = (state == WR_RESP);
  assign ar_valid  = (state == RD_REQ);
  assign r_ready   = (state == RD_RESP);
  assign res_valid = (state == OUT);
  assign aw_addr   = aw_valid ? (BASE_ADDR + {16'h0000, wr_off}) : 32'h0;
  assign w_data    = !w_valid ? 32'h0 : (wr_idx == 3'd0) ? {31'b0, mode_q} : 32'(obs_sel);
  assign w_strb    = w_valid ? 4'hF : 4'h0;
  assign ar_addr   = ar_valid ? (BASE_ADDR + 32'h0000_2000) : 32'h0;
  assign aw_prot   = 3'b000;
  assign ar_prot   = 3'b000;

endmodule

// File: tb/tb_bayes_infer_master.sv
// Directed bench for bayes_infer_master against a small AXI-Lite slave model with
// configurable error injection, read data table and a never-answering read mode.
module tb_bayes_infer_master;

  localparam int OBS_W = 9;
  localparam int R_LAT = 3;

  logic               clk, rst_n;
  logic               job_valid, job_ready, job_mode;
  logic [4*OBS_W-1:0] job_obs;
  logic               res_valid, res_ready, res_err;
  logic [31:0]        res_data;
  logic [31:0]        aw_addr, w_data, ar_addr, r_data;
  logic               aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic               ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]         w_strb;
  logic [2:0]         aw_prot, ar_prot;
  logic [1:0]         b_resp, r_resp;

  bayes_infer_master #(.BASE_ADDR(32'h0000_0000), .OBS_W(OBS_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_obs(job_obs), .job_mode(job_mode),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_prot(aw_prot),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_prot(ar_prot),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model configuration, written only by the stimulus process
  int          bad_idx;
  int          aw_base, ar_base;
  logic        r_never;
  logic [1:0]  rresp_cfg;
  logic [31:0] rdata_tab [256];

  // slave model state and handshake logs
  logic        wrdy, ardy, r_pend;
  int          r_cnt, r_idx, aw_n, ar_n, strb_bad;
  logic [31:0] aw_log [256];
  logic [31:0] w_log  [256];
  logic [31:0] ar_log [256];

  assign aw_ready = wrdy;
  assign w_ready  = wrdy;
  assign ar_ready = ardy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrdy <= 1'b0; ardy <= 1'b0; r_pend <= 1'b0; r_cnt <= 0; r_idx <= 0;
      b_valid <= 1'b0; b_resp <= 2'b00; r_valid <= 1'b0; r_resp <= 2'b00; r_data <= 32'h0;
      aw_n <= 0; ar_n <= 0; strb_bad <= 0;
    end else begin
      wrdy <= aw_valid && w_valid && !wrdy;
      ardy <= ar_valid && !ardy;
      if (aw_valid && aw_ready && w_valid && w_ready) begin
        aw_log[aw_n[7:0]] <= aw_addr;
        w_log[aw_n[7:0]]  <= w_data;
        aw_n    <= aw_n + 1;
        if (w_strb != 4'hF) strb_bad <= strb_bad + 1;
        b_valid <= 1'b1;
        b_resp  <= ((aw_n - aw_base) == bad_idx) ? 2'b10 : 2'b00;
      end else if (b_valid && b_ready) begin
        b_valid <= 1'b0;
      end
      if (ar_valid && ar_ready) begin
        ar_log[ar_n[7:0]] <= ar_addr;
        ar_n   <= ar_n + 1;
        r_idx  <= ar_n;
        r_pend <= 1'b1;
        r_cnt  <= R_LAT;
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          r_pend <= 1'b0;
          if (!r_never) begin
            r_valid <= 1'b1;
            r_data  <= rdata_tab[r_idx[7:0]];
            r_resp  <= rresp_cfg;
          end
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
      if (r_valid && r_ready) r_valid <= 1'b0;
    end
  end

  typedef struct {
    logic [8:0]  o1, o2, o3, o4;
    logic        mode;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          bad;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_nw;
    int          exp_nr;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] addr_tab [5];
  int          checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [8:0] o1, o2, o3, o4, input logic mode);
    int k;
    job_obs   = {o4, o3, o2, o1};
    job_mode  = mode;
    job_valid = 1'b1;
    k = 0;
    while (!job_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("job_accept_wait", 32'(k < 50), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] d, output logic e);
    int k;
    k = 0;
    while (!res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("res_valid_wait", 32'(k < 300), 32'd1);
    d = res_data;
    e = res_err;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_vec(input int i, input logic do_release);
    vec_t        v;
    logic [31:0] d, wexp [5];
    logic        e;
    int          nw, nr;
    v = vecs[i];
    bad_idx   = v.bad;
    rresp_cfg = v.rresp;
    aw_base   = aw_n;
    ar_base   = ar_n;
    rdata_tab[ar_n[7:0]] = v.rdata;
    wexp[0] = {31'b0, v.mode};
    wexp[1] = {23'b0, v.o1};
    wexp[2] = {23'b0, v.o2};
    wexp[3] = {23'b0, v.o3};
    wexp[4] = {23'b0, v.o4};
    start_job(v.o1, v.o2, v.o3, v.o4, v.mode);
    wait_result(d, e);
    nw = aw_n - aw_base;
    nr = ar_n - ar_base;
    chk($sformatf("v%0d_res_data", i), d, v.exp_data);
    chk($sformatf("v%0d_res_err", i), 32'(e), 32'(v.exp_err));
    chk($sformatf("v%0d_n_writes", i), nw, v.exp_nw);
    chk($sformatf("v%0d_n_reads", i), nr, v.exp_nr);
    for (int j = 0; j < v.exp_nw && j < nw; j++) begin
      chk($sformatf("v%0d_aw_addr%0d", i, j), aw_log[8'(aw_base + j)], addr_tab[j]);
      chk($sformatf("v%0d_w_data%0d", i, j), w_log[8'(aw_base + j)], wexp[j]);
    end
    if (nr > 0) chk($sformatf("v%0d_ar_addr", i), ar_log[8'(ar_base)], 32'h0000_2000);
    if (do_release) release_result();
  endtask

  initial begin
    logic [31:0] d0, d1;
    logic        e0, e1, stable;
    int          k;
    checks = 0; errors = 0;
    addr_tab = '{32'h201C, 32'h200C, 32'h2010, 32'h2014, 32'h2018};
    //            o1      o2      o3      o4      mode  rdata          rresp  bad  data          err  nw nr
    vecs[0] = '{9'h001, 9'h00A, 9'h1FF, 9'h040, 1'b1, 32'h1122_3344, 2'b00, -1, 32'h1122_3344, 1'b0, 5, 1};
    vecs[1] = '{9'h000, 9'h000, 9'h000, 9'h000, 1'b0, 32'hA5A5_5A5A, 2'b00, -1, 32'hA5A5_5A5A, 1'b0, 5, 1};
    vecs[2] = '{9'h123, 9'h0F0, 9'h155, 9'h0AA, 1'b1, 32'hDEAD_BEEF, 2'b00,  2, 32'h0000_0000, 1'b1, 3, 0};
    vecs[3] = '{9'h1FF, 9'h100, 9'h080, 9'h001, 1'b0, 32'hCAFE_F00D, 2'b10, -1, 32'h0000_0000, 1'b1, 5, 1};
    vecs[4] = '{9'h011, 9'h022, 9'h033, 9'h044, 1'b1, 32'h0102_0304, 2'b00,  0, 32'h0000_0000, 1'b1, 1, 0};
    for (int i = 0; i < 256; i++) rdata_tab[i] = 32'h0;
    bad_idx = -1; aw_base = 0; ar_base = 0; r_never = 1'b0; rresp_cfg = 2'b00;
    job_valid = 1'b0; job_obs = '0; job_mode = 1'b0; res_ready = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'd0);
    chk("rst_aw_valid", 32'(aw_valid), 32'd0);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_ar_valid", 32'(ar_valid), 32'd0);
    chk("rst_b_r_ready", {30'b0, b_ready, r_ready}, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("prot", {26'b0, aw_prot, ar_prot}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_job_ready", 32'(job_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_vec(i, 1'b1);

    // result held while the consumer stalls
    run_vec(1, 1'b0);
    d0 = res_data; e0 = res_err; stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!res_valid || res_data !== d0 || res_err !== e0 || job_ready) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    release_result();
    chk("stall_job_ready_after", 32'(job_ready), 32'd1);
    chk("stall_res_valid_after", 32'(res_valid), 32'd0);

    // read never answered: abort after exactly TIMEOUT cycles in RD_RESP
    r_never = 1'b1; bad_idx = -1; aw_base = aw_n; ar_base = ar_n;
    start_job(9'h005, 9'h006, 9'h007, 9'h008, 1'b0);
    k = 0;
    while (ar_n == ar_base && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_ar_seen", 32'(k < 200), 32'd1);
    k = 0;
    while (r_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("to_r_ready_cycles", k, 16);
    chk("to_res_valid", 32'(res_valid), 32'd1);
    chk("to_res_err", 32'(res_err), 32'd1);
    chk("to_res_data", res_data, 32'd0);
    release_result();
    r_never = 1'b0;

    // back-to-back jobs, next job presented with the result handshake
    rresp_cfg = 2'b00; bad_idx = -1; aw_base = aw_n; ar_base = ar_n;
    rdata_tab[ar_n[7:0]]       = 32'h0A0B_0C0D;
    rdata_tab[8'(ar_n + 1)]    = 32'h5060_7080;
    res_ready = 1'b1;
    start_job(9'h00F, 9'h0F0, 9'h1E0, 9'h003, 1'b1);
    wait_result(d0, e0);
    chk("b2b_first_data", d0, 32'h0A0B_0C0D);
    job_obs = {9'h004, 9'h003, 9'h002, 9'h001}; job_mode = 1'b0; job_valid = 1'b1;
    @(negedge clk);
    chk("b2b_res_valid_drop", 32'(res_valid), 32'd0);
    chk("b2b_job_ready", 32'(job_ready), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
    chk("b2b_job_taken", 32'(job_ready), 32'd0);
    wait_result(d1, e1);
    chk("b2b_second_data", d1, 32'h5060_7080);
    chk("b2b_second_err", 32'(e1), 32'd0);
    @(negedge clk);
    res_ready = 1'b0;

    // asynchronous reset in the middle of a write request
    bad_idx = -1; aw_base = aw_n;
    start_job(9'h0AB, 9'h0CD, 9'h0EF, 9'h012, 1'b1);
    chk("mid_aw_valid_before", 32'(aw_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_aw_valid_async", 32'(aw_valid), 32'd0);
    chk("mid_w_valid_async", 32'(w_valid), 32'd0);
    chk("mid_job_ready_async", 32'(job_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    aw_base = 0; ar_base = 0;
    @(negedge clk);
    chk("mid_job_ready_after", 32'(job_ready), 32'd1);
    run_vec(0, 1'b1);
    chk("w_strb_all_ones", strb_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
